euler_update_stage: RTL and testbench

//  Write-back stage downstream of the Euler matrix-vector pipeline. Each row result
//  (acc = A[i]*x) is consumed on data_ready and combined as x_next[i] = x[i] + h*acc.
//  x[i] is read from vector memory and x_next[i] is written to a shadow region, so

---
 rtl/euler_update_stage.sv | 214 +++++++++++++++++++++
 tb/tb_euler_update_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/euler_update_stage.sv
// euler_update_stage: write-back stage of the Euler integrator.
// Consumes one row result per data_ready and writes x_next[row] = x[row] + h*acc
// into the shadow region, reading x[row] from the current region.
module euler_update_stage #(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16,
  parameter int FRAC_BITS = 8,
  parameter int MAX_DIM   = 6,
  parameter int X_BASE    = 0,
  parameter int WR_BASE   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MAX_DIM-1:0]   shape_0,
  input  logic [DATA_SIZE-1:0] step_h,
  input  logic                 data_ready,
  input  logic [DATA_SIZE-1:0] out_acc,
  input  logic                 acc_overflow,
  output logic [ADD_SIZE-1:0]  vec_rd_addr,
  input  logic [DATA_SIZE-1:0] vec_rd_data,
  output logic                 vec_wr_en,
  output logic [ADD_SIZE-1:0]  vec_wr_addr,
  output logic [DATA_SIZE-1:0] vec_wr_data,
  output logic                 step_done,
  output logic                 busy,
  output logic                 overflow
);

  typedef enum logic [1:0] {S_IDLE, S_RD_X, S_MUL, S_WR} state_t;

  // Clamp a full-width product (already scaled) to DATA_SIZE; MSB of result = clamp flag.
  function automatic logic [DATA_SIZE:0] sat_prod(input logic signed [2*DATA_SIZE-1:0] v);
    logic [DATA_SIZE:0] r;
    if ((&v[2*DATA_SIZE-1:DATA_SIZE-1]) || !(|v[2*DATA_SIZE-1:DATA_SIZE-1]))
      r = {1'b0, v[DATA_SIZE-1:0]};
    else if (v[2*DATA_SIZE-1])
      r = {1'b1, 1'b1, {(DATA_SIZE-1){1'b0}}};
    else
      r = {1'b1, 1'b0, {(DATA_SIZE-1){1'b1}}};
    return r;
  endfunction

  // Clamp a one-bit-wider sum to DATA_SIZE; MSB of result = clamp flag.
  function automatic logic [DATA_SIZE:0] sat_sum(input logic signed [DATA_SIZE:0] v);
    logic [DATA_SIZE:0] r;
    if (v[DATA_SIZE] == v[DATA_SIZE-1])
      r = {1'b0, v[DATA_SIZE-1:0]};
    else if (v[DATA_SIZE])
      r = {1'b1, 1'b1, {(DATA_SIZE-1){1'b0}}};
    else
      r = {1'b1, 1'b0, {(DATA_SIZE-1){1'b1}}};
    return r;
  endfunction

  // control state
  state_t               r_state;
  state_t               w_state_nxt;
  logic [MAX_DIM-1:0]   r_row;
  logic [MAX_DIM-1:0]   r_shape;
  logic                 r_busy;
  logic                 r_ovf;
  logic [1:0]           r_fifo_cnt;
  logic                 r_fifo_wptr;
  logic                 r_fifo_rptr;
  logic [ADD_SIZE-1:0]  r_rd_addr_hold;

  // datapath registers (no reset: qualified by control state)
  logic signed [DATA_SIZE-1:0] r_fifo_mem [2];
  logic signed [DATA_SIZE-1:0] r_h;
  logic signed [DATA_SIZE-1:0] r_acc_p0;
  logic signed [DATA_SIZE-1:0] r_x_p1;
  logic signed [DATA_SIZE-1:0] r_prod_p1;

  logic                          w_push_req;
  logic                          w_push_ok;
  logic                          w_drop;
  logic                          w_pop;
  logic                          w_fifo_full;
  logic                          w_fifo_widx;
  logic                          w_last_row;
  logic                          w_wr_en;
  logic                          w_done;
  logic [ADD_SIZE-1:0]           w_x_addr;
  logic signed [2*DATA_SIZE-1:0] w_prod_full;
  logic signed [2*DATA_SIZE-1:0] w_prod_shr;
  logic                          w_prod_sat;
  logic signed [DATA_SIZE-1:0]   w_prod_val;
  logic signed [DATA_SIZE:0]     w_sum;
  logic                          w_sum_sat;
  logic signed [DATA_SIZE-1:0]   w_sum_val;

  // A start clears the FIFO first, so a same-cycle push always lands in slot 0.
  assign w_fifo_full = (r_fifo_cnt == 2'd2);
  assign w_pop       = (r_state == S_RD_X) && !start;
  assign w_push_req  = data_ready && (r_busy || start);
  assign w_push_ok   = w_push_req && (start || !w_fifo_full || w_pop);
  assign w_drop      = w_push_req && !start && w_fifo_full && !w_pop;
  assign w_fifo_widx = start ? 1'b0 : r_fifo_wptr;

  assign w_last_row  = (r_row == (r_shape - MAX_DIM'(1)));
  assign w_x_addr    = ADD_SIZE'(X_BASE) + ADD_SIZE'(r_row);

  assign w_prod_full = (2*DATA_SIZE)'(r_acc_p0) * (2*DATA_SIZE)'(r_h);
  assign w_prod_shr  = w_prod_full >>> FRAC_BITS;
  assign {w_prod_sat, w_prod_val} = sat_prod(w_prod_shr);

  assign w_sum = (DATA_SIZE+1)'(r_x_p1) + (DATA_SIZE+1)'(r_prod_p1);
  assign {w_sum_sat, w_sum_val} = sat_sum(w_sum);

  // Next-state and strobe decode; a start in any state aborts back to IDLE without writing.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: if (r_busy && (r_fifo_cnt != 2'd0)) w_state_nxt = S_RD_X;
      S_RD_X: w_state_nxt = S_MUL;
      S_MUL:  w_state_nxt = S_WR;
      S_WR: begin
        w_wr_en = 1'b1;
        if (w_last_row) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_fifo_cnt != 2'd0) begin
          w_state_nxt = S_RD_X;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (start) begin
      w_state_nxt = S_IDLE;
      w_wr_en     = 1'b0;
      w_done      = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Step bookkeeping: row counter, busy, sampled shape, sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row   <= '0;
      r_shape <= '0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (start) begin
      r_row   <= '0;
      r_shape <= shape_0;
      r_busy  <= 1'b1;
      r_ovf   <= acc_overflow;
    end else begin
      if (w_wr_en) r_row <= w_done ? '0 : r_row + MAX_DIM'(1);
      if (w_done)  r_busy <= 1'b0;
      r_ovf <= r_ovf | acc_overflow | w_drop
             | (w_wr_en && w_sum_sat)
             | ((r_state == S_MUL) && w_prod_sat);
    end
  end

  // Two-entry input FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo_cnt  <= 2'd0;
      r_fifo_wptr <= 1'b0;
      r_fifo_rptr <= 1'b0;
    end else if (start) begin
      r_fifo_cnt  <= w_push_ok ? 2'd1 : 2'd0;
      r_fifo_wptr <= w_push_ok;
      r_fifo_rptr <= 1'b0;
    end else begin
      if (w_push_ok) r_fifo_wptr <= ~r_fifo_wptr;
      if (w_pop)     r_fifo_rptr <= ~r_fifo_rptr;
      unique case ({w_push_ok, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Remember the last x address so the read port holds steady between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_rd_addr_hold <= '0;
    else if (r_state == S_RD_X) r_rd_addr_hold <= w_x_addr;
  end

  // Datapath: FIFO storage, h capture, p0 = popped acc, p1 = x and scaled product.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo_mem[w_fifo_widx] <= out_acc;
    if (start) r_h <= step_h;
    if (r_state == S_RD_X) r_acc_p0 <= r_fifo_mem[r_fifo_rptr];
    // ---- p0 -> p1 boundary ----
    if (r_state == S_MUL) begin
      r_x_p1    <= vec_rd_data;
      r_prod_p1 <= w_prod_val;
    end
  end

  assign vec_rd_addr = (r_state == S_RD_X) ? w_x_addr : r_rd_addr_hold;
  assign vec_wr_en   = w_wr_en;
  assign vec_wr_addr = w_wr_en ? (ADD_SIZE'(WR_BASE) + ADD_SIZE'(r_row)) : '0;
  assign vec_wr_data = w_wr_en ? w_sum_val : '0;
  assign step_done   = w_done;
  assign busy        = r_busy;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_euler_update_stage.sv
// Bench for euler_update_stage: directed steps plus randomized steps,
// each write checked against an arithmetic reference of x + h*acc.
module tb_euler_update_stage;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int XB = 8;
  localparam int WB = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [5:0]    shape_0 = '0;
  logic [DW-1:0] step_h = '0;
  logic          data_ready = 1'b0;
  logic [DW-1:0] out_acc = '0;
  logic          acc_overflow = 1'b0;
  logic [AW-1:0] vec_rd_addr;
  logic [DW-1:0] vec_rd_data = '0;
  logic          vec_wr_en;
  logic [AW-1:0] vec_wr_addr;
  logic [DW-1:0] vec_wr_data;
  logic          step_done;
  logic          busy;
  logic          overflow;

  euler_update_stage #(.X_BASE(XB), .WR_BASE(WB)) dut (
    .clk(clk), .rst(rst), .start(start), .shape_0(shape_0), .step_h(step_h),
    .data_ready(data_ready), .out_acc(out_acc), .acc_overflow(acc_overflow),
    .vec_rd_addr(vec_rd_addr), .vec_rd_data(vec_rd_data), .vec_wr_en(vec_wr_en),
    .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data), .step_done(step_done),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // vector memory: registered read, data one cycle after the address
  logic [DW-1:0] xmem [65536];
  always @(posedge clk) vec_rd_data <= xmem[vec_rd_addr];

  typedef struct { int addr; int data; bit dn; int cyc; } wr_t;
  wr_t wq[$];
  int  stray_done = 0;
  always @(negedge clk) begin
    if (rst && vec_wr_en) wq.push_back('{int'(vec_wr_addr), int'(vec_wr_data), step_done, cyc});
    if (rst && step_done && !vec_wr_en) stray_done++;
  end

  int n_vec = 0;
  int n_err = 0;
  shortint accq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_step(input int shape, input shortint h);
    start = 1'b1; shape_0 = 6'(shape); step_h = h;
    tick(1);
    start = 1'b0;
  endtask

  task automatic dr(input shortint a);
    data_ready = 1'b1; out_acc = a;
    tick(1);
    data_ready = 1'b0;
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    int k = 0;
    while (wq.size() < n && k < budget) begin tick(1); k++; end
    if (wq.size() < n) chk({tag, "_timeout"}, wq.size(), n);
  endtask

  // x + ((acc*h) >> 8) with both results clamped to the signed 16-bit range; bit 16 = clamped
  function automatic logic [16:0] ref_upd(input shortint x, input shortint acc, input shortint h);
    longint p, s;
    bit sat;
    sat = 1'b0;
    p = (longint'(acc) * longint'(h)) >>> 8;
    if (p > 32767) begin p = 32767; sat = 1'b1; end
    else if (p < -32768) begin p = -32768; sat = 1'b1; end
    s = longint'(x) + p;
    if (s > 32767) begin s = 32767; sat = 1'b1; end
    else if (s < -32768) begin s = -32768; sat = 1'b1; end
    return {sat, 16'(s)};
  endfunction

  // One full step: start, push accq with the given spacing, check every write.
  task automatic run_step(input int shape, input shortint h, input int gap, input string tag);
    bit sat_any;
    logic [16:0] e;
    sat_any = 1'b0;
    wq.delete();
    start_step(shape, h);
    chk({tag, "_ovf_clear"}, overflow, 0);
    foreach (accq[i]) begin
      dr(accq[i]);
      tick(gap);
    end
    wait_wr(shape, 20 + 8 * shape, tag);
    for (int i = 0; i < shape; i++) begin
      if (i < wq.size()) begin
        e = ref_upd(shortint'(xmem[XB+i]), accq[i], h);
        sat_any |= e[16];
        chk($sformatf("%s_addr%0d", tag, i), wq[i].addr, WB + i);
        chk($sformatf("%s_data%0d", tag, i), wq[i].data, {16'h0, e[15:0]});
        chk($sformatf("%s_done%0d", tag, i), wq[i].dn, (i == shape - 1));
      end
    end
    tick(3);
    chk({tag, "_nwrites"}, wq.size(), shape);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_ovf"}, overflow, sat_any);
  endtask

  initial begin
    int t_push;
    logic [16:0] e;
    for (int i = 0; i < 128; i++) xmem[i] = '0;

    // reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_wr_en", vec_wr_en, 0);
    chk("rst_done", step_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rd_addr", vec_rd_addr, 0);
    chk("rst_wr_addr", vec_wr_addr, 0);
    chk("rst_wr_data", vec_wr_data, 0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // data_ready while idle is ignored
    dr(16'h1234);
    tick(6);
    chk("idle_ignore", wq.size(), 0);

    // single row, latency
    xmem[XB] = 16'h0100;
    wq.delete();
    start_step(1, 16'h0080);
    chk("t1_busy", busy, 1);
    t_push = cyc + 1;
    dr(16'h0200);
    wait_wr(1, 20, "t1");
    if (wq.size() >= 1) begin
      chk("t1_addr", wq[0].addr, 64);
      chk("t1_data", wq[0].data, 32'h0200);
      chk("t1_done", wq[0].dn, 1);
      chk("t1_latency", wq[0].cyc, t_push + 3);
    end
    tick(1);
    chk("t1_rd_hold", vec_rd_addr, XB);
    chk("t1_busy_after", busy, 0);
    chk("t1_wr_idle_addr", vec_wr_addr, 0);

    // three rows
    xmem[XB] = 16'h0000; xmem[XB+1] = 16'h0100; xmem[XB+2] = 16'h7F00;
    accq.delete(); accq.push_back(16'h0100); accq.push_back(16'hFF00); accq.push_back(16'h0000);
    run_step(3, 16'h0100, 4, "t2");
    if (wq.size() == 3) chk("t2_row1_const", wq[1].data, 32'h0000);

    // saturation both directions
    xmem[XB] = 16'h7F00;
    accq.delete(); accq.push_back(16'h7F00);
    run_step(1, 16'h0100, 2, "t3p");
    if (wq.size() >= 1) chk("t3p_const", wq[0].data, 32'h7FFF);
    xmem[XB] = 16'h8100;
    accq.delete(); accq.push_back(16'h8100);
    run_step(1, 16'h0100, 2, "t3n");
    if (wq.size() >= 1) chk("t3n_const", wq[0].data, 32'h8000);

    // back-to-back pulses, FIFO at capacity without loss
    for (int i = 0; i < 3; i++) xmem[XB+i] = 16'(i * 16'h0111);
    accq.delete(); accq.push_back(16'h0040); accq.push_back(-16'sh0080); accq.push_back(16'h0300);
    run_step(3, 16'h0100, 0, "t4");

    // four back-to-back pulses: fourth dropped, overflow set
    accq.delete(); accq.push_back(16'h0010); accq.push_back(16'h0020);
    accq.push_back(16'h0030); accq.push_back(16'h0040);
    wq.delete();
    start_step(3, 16'h0100);
    foreach (accq[i]) begin data_ready = 1'b1; out_acc = accq[i]; tick(1); end
    data_ready = 1'b0;
    wait_wr(3, 40, "t4d");
    for (int i = 0; i < 3; i++) begin
      if (i < wq.size()) begin
        e = ref_upd(shortint'(xmem[XB+i]), accq[i], 16'sh0100);
        chk($sformatf("t4d_data%0d", i), wq[i].data, {16'h0, e[15:0]});
      end
    end
    tick(8);
    chk("t4d_nwrites", wq.size(), 3);
    chk("t4d_ovf", overflow, 1);

    // reset in the middle of a row
    xmem[XB] = 16'h0100;
    wq.delete();
    start_step(1, 16'h0080);
    dr(16'h0200);
    tick(2);
    rst = 1'b0;
    #1;
    chk("t5_wr_en", vec_wr_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rd_addr", vec_rd_addr, 0);
    chk("t5_wr_data", vec_wr_data, 0);
    chk("t5_done", step_done, 0);
    tick(3);
    rst = 1'b1;
    tick(6);
    chk("t5_no_stale", wq.size(), 0);
    xmem[XB] = 16'h0300; xmem[XB+1] = 16'hFE00;
    accq.delete(); accq.push_back(16'h0100); accq.push_back(16'h0400);
    run_step(2, 16'h0040, 3, "t5c");

    // restart in the middle of row 1
    for (int i = 0; i < 3; i++) xmem[XB+i] = 16'($urandom_range(0, 16'h0FFF));
    wq.delete();
    start_step(3, 16'h0100);
    dr(16'h0050);
    wait_wr(1, 20, "t6a");
    dr(16'h0060);
    tick(2);
    chk("t6_before_abort", wq.size(), 1);
    accq.delete(); accq.push_back(16'h0011); accq.push_back(16'h0022);
    run_step(2, 16'h0200, 3, "t6b");

    // randomized steps
    for (int r = 0; r < 6; r++) begin
      int shp;
      shortint h;
      shp = $urandom_range(1, 6);
      h = shortint'($urandom_range(0, 16'hFFFF));
      for (int i = 0; i < shp; i++) xmem[XB+i] = 16'($urandom);
      accq.delete();
      for (int i = 0; i < shp; i++) accq.push_back(shortint'($urandom));
      run_step(shp, h, $urandom_range(2, 5), $sformatf("rnd%0d", r));
    end

    chk("stray_done", stray_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
